// File: rtl/fp_pkg.sv
// Shared types and constants for the FP32 add/sub result stage.
package fp_pkg;

    localparam logic [1:0] SEL_INF    = 2'b00;
    localparam logic [1:0] SEL_QNAN   = 2'b01;
    localparam logic [1:0] SEL_PROP_A = 2'b10;
    localparam logic [1:0] SEL_PROP_B = 2'b11;

    localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] man;
    } fp32_t;

    typedef struct packed {
        logic nan;
        logic inf;
        logic zero;
        logic ovf;
    } fp_flags_t;

    typedef struct packed {
        fp32_t     word;
        fp_flags_t flags;
    } fp_pkt_t;

endpackage

// File: rtl/fp_skid_buf.sv
// One-entry skid buffer feeding a registered output; 1-cycle latency, full throughput.
// o_ready is taken straight from the skid-valid flop, so it never depends on i_ready combinationally.
module fp_skid_buf #(
    parameter int W = 36
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_valid,
    output logic         o_ready,
    input  logic [W-1:0] i_data,
    output logic         o_valid,
    input  logic         i_ready,
    output logic [W-1:0] o_data
);

    logic         out_vld_q, out_vld_d;
    logic [W-1:0] out_dat_q, out_dat_d;
    logic         skid_vld_q, skid_vld_d;
    logic [W-1:0] skid_dat_q, skid_dat_d;
    logic         accept;

    assign o_ready = ~skid_vld_q;
    assign o_valid = out_vld_q;
    assign o_data  = out_dat_q;
    assign accept  = i_valid & ~skid_vld_q;

    always_comb begin
        out_vld_d  = out_vld_q;
        out_dat_d  = out_dat_q;
        skid_vld_d = skid_vld_q;
        skid_dat_d = skid_dat_q;
        if (~out_vld_q | i_ready) begin
            // A held skid entry always drains first; accept is 0 whenever skid is full.
            if (skid_vld_q) begin
                out_vld_d  = 1'b1;
                out_dat_d  = skid_dat_q;
                skid_vld_d = 1'b0;
            end else begin
                out_vld_d = accept;
                if (accept) begin
                    out_dat_d = i_data;
                end
            end
        end else if (accept) begin
            skid_vld_d = 1'b1;
            skid_dat_d = i_data;
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            out_vld_q  <= 1'b0;
            out_dat_q  <= '0;
            skid_vld_q <= 1'b0;
            skid_dat_q <= '0;
        end else begin
            out_vld_q  <= out_vld_d;
            out_dat_q  <= out_dat_d;
            skid_vld_q <= skid_vld_d;
            skid_dat_q <= skid_dat_d;
        end
    end

endmodule

// File: rtl/fp_result_pack.sv
// Packs the FP32 add/sub result from normal-path and special-case selects, with status flags.
// One cycle latency through a skid-buffered output; back-pressure never drops or duplicates results.
module fp_result_pack
    import fp_pkg::*;
#(
    parameter logic [22:0] QNAN_MAN  = 23'h400000,
    parameter logic [31:0] CANON_NAN = 32'h7FC00000
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic        i_sign_norm,
    input  logic [7:0]  i_exp_norm,
    input  logic [22:0] i_man_norm,
    input  logic        i_ovf,
    input  logic        i_sel_exp,
    input  logic [1:0]  i_sel_man,
    input  logic        i_sign_spec,
    input  logic        i_sign_a,
    input  logic [22:0] i_man_a,
    input  logic        i_sign_b,
    input  logic [22:0] i_man_b,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [31:0] o_result,
    output logic        o_flag_nan,
    output logic        o_flag_inf,
    output logic        o_flag_zero,
    output logic        o_flag_ovf
);

    fp_pkt_t pkt_in;
    fp_pkt_t pkt_out;
    logic [$bits(fp_pkt_t)-1:0] pkt_out_raw;

    always_comb begin
        pkt_in = '0;
        if (i_sel_exp) begin
            case (i_sel_man)
                SEL_INF: begin
                    pkt_in.word      = '{sign: i_sign_spec, exp: EXP_ALL_ONES, man: '0};
                    pkt_in.flags.inf = 1'b1;
                end
                SEL_QNAN: begin
                    pkt_in.word      = fp32_t'(CANON_NAN);
                    pkt_in.flags.nan = 1'b1;
                end
                SEL_PROP_A: begin
                    pkt_in.word      = '{sign: i_sign_a, exp: EXP_ALL_ONES, man: i_man_a | QNAN_MAN};
                    pkt_in.flags.nan = 1'b1;
                end
                default: begin
                    pkt_in.word      = '{sign: i_sign_b, exp: EXP_ALL_ONES, man: i_man_b | QNAN_MAN};
                    pkt_in.flags.nan = 1'b1;
                end
            endcase
        end else if (i_ovf) begin
            pkt_in.word      = '{sign: i_sign_norm, exp: EXP_ALL_ONES, man: '0};
            pkt_in.flags.inf = 1'b1;
            pkt_in.flags.ovf = 1'b1;
        end else begin
            pkt_in.word       = '{sign: i_sign_norm, exp: i_exp_norm, man: i_man_norm};
            pkt_in.flags.zero = (i_exp_norm == 8'h00) && (i_man_norm == 23'h0);
        end
    end

    fp_skid_buf #(
        .W($bits(fp_pkt_t))
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_data  (pkt_in),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_data  (pkt_out_raw)
    );

    assign pkt_out     = fp_pkt_t'(pkt_out_raw);
    assign o_result    = pkt_out.word;
    assign o_flag_nan  = pkt_out.flags.nan;
    assign o_flag_inf  = pkt_out.flags.inf;
    assign o_flag_zero = pkt_out.flags.zero;
    assign o_flag_ovf  = pkt_out.flags.ovf;

endmodule

// File: tb/tb_fp_result_pack.sv
// Scoreboard bench for fp_result_pack: driver queues expected words on accept, monitor checks on transfer.
module tb_fp_result_pack;

    typedef struct {
        bit          sel_exp;
        bit [1:0]    sel_man;
        bit          ovf;
        bit          sign_norm;
        bit [7:0]    exp_norm;
        bit [22:0]   man_norm;
        bit          sign_spec;
        bit          sign_a;
        bit [22:0]   man_a;
        bit          sign_b;
        bit [22:0]   man_b;
        bit [31:0]   exp_word;
        bit [3:0]    exp_flags;   // {nan, inf, zero, ovf}
    } vec_t;

    typedef struct {
        bit [31:0] word;
        bit [3:0]  flags;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic        i_sign_norm = 1'b0;
    logic [7:0]  i_exp_norm = '0;
    logic [22:0] i_man_norm = '0;
    logic        i_ovf = 1'b0;
    logic        i_sel_exp = 1'b0;
    logic [1:0]  i_sel_man = '0;
    logic        i_sign_spec = 1'b0;
    logic        i_sign_a = 1'b0;
    logic [22:0] i_man_a = '0;
    logic        i_sign_b = 1'b0;
    logic [22:0] i_man_b = '0;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [31:0] o_result;
    logic        o_flag_nan, o_flag_inf, o_flag_zero, o_flag_ovf;

    int n_chk  = 0;
    int n_fail = 0;
    exp_t exp_q[$];
    vec_t v[10];

    always #5 clk = ~clk;

    fp_result_pack dut (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_valid     (i_valid),
        .o_ready     (o_ready),
        .i_sign_norm (i_sign_norm),
        .i_exp_norm  (i_exp_norm),
        .i_man_norm  (i_man_norm),
        .i_ovf       (i_ovf),
        .i_sel_exp   (i_sel_exp),
        .i_sel_man   (i_sel_man),
        .i_sign_spec (i_sign_spec),
        .i_sign_a    (i_sign_a),
        .i_man_a     (i_man_a),
        .i_sign_b    (i_sign_b),
        .i_man_b     (i_man_b),
        .o_valid     (o_valid),
        .i_ready     (i_ready),
        .o_result    (o_result),
        .o_flag_nan  (o_flag_nan),
        .o_flag_inf  (o_flag_inf),
        .o_flag_zero (o_flag_zero),
        .o_flag_ovf  (o_flag_ovf)
    );

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic vec_t mk(input bit se, input bit [1:0] sm, input bit ov, input bit sn,
                                input bit [7:0] e, input bit [22:0] m, input bit ss,
                                input bit sa, input bit [22:0] ma, input bit sb, input bit [22:0] mb,
                                input bit [31:0] w, input bit [3:0] f);
        vec_t r;
        r.sel_exp = se;  r.sel_man = sm;  r.ovf = ov;  r.sign_norm = sn;
        r.exp_norm = e;  r.man_norm = m;  r.sign_spec = ss;
        r.sign_a = sa;   r.man_a = ma;    r.sign_b = sb; r.man_b = mb;
        r.exp_word = w;  r.exp_flags = f;
        return r;
    endfunction

    // Applies one cycle of stimulus at the falling edge; reports whether it will be accepted.
    task automatic step(input bit vld, input vec_t x, input bit rdy, output bit acc);
        exp_t e;
        @(negedge clk);
        i_valid = vld;       i_ready = rdy;
        i_sel_exp = x.sel_exp; i_sel_man = x.sel_man; i_ovf = x.ovf;
        i_sign_norm = x.sign_norm; i_exp_norm = x.exp_norm; i_man_norm = x.man_norm;
        i_sign_spec = x.sign_spec; i_sign_a = x.sign_a; i_man_a = x.man_a;
        i_sign_b = x.sign_b; i_man_b = x.man_b;
        #1;
        acc = vld && (o_ready === 1'b1);
        if (acc) begin
            e.word = x.exp_word; e.flags = x.exp_flags;
            exp_q.push_back(e);
        end
    endtask

    // Sends one vector with i_ready=1, retrying for a bounded number of cycles.
    task automatic send(input vec_t x, input string name);
        bit acc = 1'b0;
        for (int k = 0; k < 8 && !acc; k++) step(1'b1, x, 1'b1, acc);
        chk({name, "_accept"}, 64'(acc), 64'd1);
    endtask

    // Monitor: a transfer happens at the next rising edge when o_valid & i_ready.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst && o_valid === 1'b1 && i_ready === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_output", 64'(o_result), 64'hDEAD_BEEF_0000_0000);
                end else begin
                    e = exp_q.pop_front();
                    chk("out_word", 64'(o_result), 64'(e.word));
                    chk("out_flags", 64'({o_flag_nan, o_flag_inf, o_flag_zero, o_flag_ovf}), 64'(e.flags));
                end
            end
        end
    end

    initial begin
        bit acc;
        vec_t idle;
        //          se sm    ov sn e      m          ss sa ma          sb mb          word          flags
        v[0] = mk(0, 2'b00, 0, 0, 8'h80, 23'h200000, 0, 0, 23'h0,      0, 23'h0,      32'h40200000, 4'b0000);
        v[1] = mk(1, 2'b01, 0, 0, 8'h00, 23'h0,      0, 1, 23'h7,      1, 23'h9,      32'h7FC00000, 4'b1000);
        v[2] = mk(1, 2'b10, 0, 0, 8'h00, 23'h0,      0, 1, 23'h000123, 0, 23'h000456, 32'hFFC00123, 4'b1000);
        v[3] = mk(1, 2'b11, 0, 1, 8'h00, 23'h0,      1, 1, 23'h000123, 0, 23'h400001, 32'h7FC00001, 4'b1000);
        v[4] = mk(0, 2'b00, 1, 1, 8'h12, 23'h345,    0, 0, 23'h0,      0, 23'h0,      32'hFF800000, 4'b0101);
        v[5] = mk(0, 2'b00, 0, 1, 8'h00, 23'h0,      0, 0, 23'h0,      0, 23'h0,      32'h80000000, 4'b0010);
        v[6] = mk(1, 2'b00, 0, 0, 8'h55, 23'h1,      1, 0, 23'h0,      0, 23'h0,      32'hFF800000, 4'b0100);
        v[7] = mk(0, 2'b01, 0, 0, 8'h7F, 23'h0,      0, 0, 23'h0,      0, 23'h0,      32'h3F800000, 4'b0000);
        v[8] = mk(1, 2'b01, 1, 1, 8'h00, 23'h0,      0, 0, 23'h0,      0, 23'h0,      32'h7FC00000, 4'b1000);
        v[9] = mk(0, 2'b00, 0, 0, 8'h00, 23'h1,      0, 0, 23'h0,      0, 23'h0,      32'h00000001, 4'b0000);
        idle = v[0];

        // Reset state
        #1;
        chk("rst_o_valid", 64'(o_valid), 64'd0);
        chk("rst_o_ready", 64'(o_ready), 64'd1);
        chk("rst_o_result", 64'(o_result), 64'd0);
        chk("rst_flags", 64'({o_flag_nan, o_flag_inf, o_flag_zero, o_flag_ovf}), 64'd0);
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // First-result latency: visible one edge after accept
        step(1'b1, v[0], 1'b1, acc);
        chk("lat_accept", 64'(acc), 64'd1);
        step(1'b0, idle, 1'b1, acc);
        chk("lat_o_valid", 64'(o_valid), 64'd1);
        chk("lat_o_result", 64'(o_result), 64'h40200000);
        step(1'b0, idle, 1'b1, acc);
        chk("drain_o_valid", 64'(o_valid), 64'd0);
        chk("drain_hold_result", 64'(o_result), 64'h40200000);

        // Back-to-back pack cases at full throughput
        for (int i = 1; i < 10; i++) send(v[i], $sformatf("vec%0d", i));
        step(1'b0, idle, 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);

        // Back-pressure: R0..R3 with i_ready low for three cycles
        step(1'b1, v[0], 1'b0, acc);  chk("bp_r0_accept", 64'(acc), 64'd1);
        step(1'b1, v[1], 1'b0, acc);  chk("bp_r1_accept", 64'(acc), 64'd1);
        step(1'b1, v[2], 1'b0, acc);  chk("bp_r2_blocked", 64'(acc), 64'd0);
        chk("bp_o_ready_low", 64'(o_ready), 64'd0);
        chk("bp_r0_held", 64'(o_result), 64'h40200000);
        chk("bp_o_valid", 64'(o_valid), 64'd1);
        step(1'b1, v[2], 1'b1, acc);  chk("bp_release_blocked", 64'(acc), 64'd0);
        step(1'b1, v[2], 1'b1, acc);  chk("bp_r2_accept", 64'(acc), 64'd1);
        chk("bp_o_ready_back", 64'(o_ready), 64'd1);
        step(1'b1, v[3], 1'b1, acc);  chk("bp_r3_accept", 64'(acc), 64'd1);
        step(1'b0, idle, 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("bp_drained_q", 64'(exp_q.size()), 64'd0);

        // Reset with both entries full
        step(1'b1, v[4], 1'b0, acc);
        step(1'b1, v[5], 1'b0, acc);
        step(1'b0, idle, 1'b0, acc);
        chk("full_o_ready", 64'(o_ready), 64'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("mid_rst_o_valid", 64'(o_valid), 64'd0);
        chk("mid_rst_o_ready", 64'(o_ready), 64'd1);
        chk("mid_rst_o_result", 64'(o_result), 64'd0);
        #3 rst = 1'b0;
        step(1'b1, v[6], 1'b1, acc);  chk("post_rst_accept", 64'(acc), 64'd1);
        step(1'b0, idle, 1'b1, acc);
        chk("post_rst_o_valid", 64'(o_valid), 64'd1);
        chk("post_rst_o_result", 64'(o_result), 64'hFF800000);

        // Bounded drain of anything still in flight
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) step(1'b0, idle, 1'b1, acc);
        step(1'b0, idle, 1'b1, acc);
        chk("final_queue_empty", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
